// File: rtl/clock_divider_prog.sv
// clock_divider_prog: NCH-channel programmable 50% duty clock divider with tick strobes and glitch-free divisor updates.
// Optional TICK_CNT_EN adds a 16-bit rising-edge counter per channel on tick_cnt_o.
module clock_divider_prog #(
    parameter int NCH     = 4,
    parameter int CW      = 32,
    parameter int DEF_DIV = 49999
) (
    input  logic                                     clk_i,
    input  logic                                     reset,
    input  logic                                     en_i,
    input  logic                                     sync_i,
    input  logic                                     cfg_valid_i,
    output logic                                     cfg_ready_o,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch_i,
    input  logic [CW-1:0]                            cfg_div_i,
    output logic [NCH-1:0]                           clk_o,
    output logic [NCH-1:0]                           tick_o
`ifdef TICK_CNT_EN
    ,
    output logic [NCH*16-1:0]                        tick_cnt_o
`endif
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] pend_v;

    // Indices with no channel behind them always read as ready
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (cfg_ch_i == CHW'(i)) cfg_ready_o = ~pend_v[i];
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d, act_q, act_d, pdiv_q, pdiv_d, nxt_div;
        logic          clk_q, clk_d, tick_q, tick_d, pend_q, pend_d;
        logic          tc, xfer, bnd;

        assign xfer    = cfg_valid_i & ~pend_q & (cfg_ch_i == CHW'(k));
        assign tc      = cnt_q == act_q;
        // Divisor changes only land on a half-period boundary or a sync restart
        assign bnd     = sync_i | (en_i & tc);
        assign nxt_div = xfer ? cfg_div_i : (pend_q ? pdiv_q : act_q);

        always_comb begin
            cnt_d  = bnd ? '0 : cnt_q + CW'(en_i);
            clk_d  = sync_i ? 1'b0 : clk_q ^ (en_i & tc);
            tick_d = ~sync_i & en_i & tc;
            act_d  = bnd ? nxt_div : act_q;
            pend_d = ~bnd & (pend_q | xfer);
            pdiv_d = xfer ? cfg_div_i : pdiv_q;
        end

        always_ff @(posedge clk_i) begin
            if (reset) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                act_q  <= CW'(DEF_DIV);
                pend_q <= 1'b0;
                pdiv_q <= '0;
            end else begin
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                act_q  <= act_d;
                pend_q <= pend_d;
                pdiv_q <= pdiv_d;
            end
        end

        assign clk_o[k]  = clk_q;
        assign tick_o[k] = tick_q;
        assign pend_v[k] = pend_q;

`ifdef TICK_CNT_EN
        logic [15:0] tcnt_q, tcnt_d;

        assign tcnt_d = sync_i ? '0 : tcnt_q + 16'(en_i & tc & ~clk_q);

        always_ff @(posedge clk_i) begin
            if (reset) tcnt_q <= '0;
            else tcnt_q <= tcnt_d;
        end

        assign tick_cnt_o[16*k +: 16] = tcnt_q;
`endif
    end
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: directed and randomized checks of clock_divider_prog against a countdown reference model.
module tb_clock_divider_prog;
    localparam int DEF = 4;

    logic       clk = 1'b0;
    logic       reset, en, sync, cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       rdy4, rdy3;
    logic [3:0] clk4, tick4;
    logic [2:0] clk3, tick3;
`ifdef TICK_CNT_EN
    logic [63:0] tcnt4;
    logic [47:0] tcnt3;
`endif

    int pass = 0, total = 0;

    // Model: each channel counts down the enabled cycles left in its half-period
    int         m_left[4], m_hp[4], m_pdiv[4];
    bit         m_pend[4];
    logic [3:0] m_clk, m_tick;
    logic [15:0] m_rise[4];

    clock_divider_prog #(.NCH(4), .CW(8), .DEF_DIV(DEF)) dut (
        .clk_i(clk), .reset(reset), .en_i(en), .sync_i(sync), .cfg_valid_i(cfg_valid),
        .cfg_ready_o(rdy4), .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .clk_o(clk4), .tick_o(tick4)
`ifdef TICK_CNT_EN
        , .tick_cnt_o(tcnt4)
`endif
    );

    clock_divider_prog #(.NCH(3), .CW(8), .DEF_DIV(DEF)) dut3 (
        .clk_i(clk), .reset(reset), .en_i(en), .sync_i(sync), .cfg_valid_i(cfg_valid),
        .cfg_ready_o(rdy3), .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .clk_o(clk3), .tick_o(tick3)
`ifdef TICK_CNT_EN
        , .tick_cnt_o(tcnt3)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                m_hp[c] = DEF + 1;
                m_left[c] = DEF + 1;
                m_pend[c] = 0;
                m_rise[c] = 0;
            end
            m_clk = 0;
            m_tick = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                bit xf;
                int nh;
                xf = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
                nh = xf ? int'(cfg_div) + 1 : (m_pend[c] ? m_pdiv[c] + 1 : m_hp[c]);
                if (sync) begin
                    m_hp[c] = nh;
                    m_left[c] = nh;
                    m_clk[c] = 0;
                    m_tick[c] = 0;
                    m_pend[c] = 0;
                    m_rise[c] = 0;
                end else begin
                    m_tick[c] = 0;
                    if (en) m_left[c]--;
                    if (en && m_left[c] == 0) begin
                        m_clk[c] = ~m_clk[c];
                        if (m_clk[c]) m_rise[c]++;
                        m_tick[c] = 1;
                        m_hp[c] = nh;
                        m_left[c] = nh;
                        m_pend[c] = 0;
                    end else if (xf) begin
                        m_pend[c] = 1;
                        m_pdiv[c] = int'(cfg_div);
                    end
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; en = 1; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
        advance();
        advance();
        total++; if (clk4 !== 4'h0) $display("FAIL reset_clk got %h want 0", clk4); else pass++;
        total++; if (tick4 !== 4'h0) $display("FAIL reset_tick got %h want 0", tick4); else pass++;
        total++; if (rdy4 !== 1'b1) $display("FAIL reset_ready got %b want 1", rdy4); else pass++;
        total++; if (clk3 !== 3'h0) $display("FAIL reset_clk3 got %h want 0", clk3); else pass++;
    endtask

    task automatic test_default();
        reset = 0;
        for (int i = 1; i <= 20; i++) begin
            advance();
            total++; if (clk4 !== (((i / 5) % 2) ? 4'hf : 4'h0)) $display("FAIL default_clk cyc %0d got %h want %h", i, clk4, ((i / 5) % 2) ? 4'hf : 4'h0); else pass++;
            total++; if (tick4 !== ((i % 5 == 0) ? 4'hf : 4'h0)) $display("FAIL default_tick cyc %0d got %h want %h", i, tick4, (i % 5 == 0) ? 4'hf : 4'h0); else pass++;
        end
    endtask

    task automatic test_cfg();
        advance();
        advance();
        cfg_valid = 1; cfg_ch = 2; cfg_div = 1;
        #1;
        total++; if (rdy4 !== 1'b1) $display("FAIL cfg_ready_before got %b want 1", rdy4); else pass++;
        advance();
        cfg_valid = 0;
        #1;
        total++; if (rdy4 !== 1'b0) $display("FAIL cfg_ready_after got %b want 0", rdy4); else pass++;
        for (int i = 0; i < 16; i++) begin
            advance();
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL cfg_out cyc %0d got %h/%h want %h/%h", i, clk4, tick4, m_clk, m_tick); else pass++;
            total++; if (rdy4 !== !m_pend[2]) $display("FAIL cfg_ready cyc %0d got %b want %b", i, rdy4, !m_pend[2]); else pass++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        cfg_valid = 1; cfg_ch = 2; cfg_div = 3;
        advance();
        cfg_div = 6;
        #1;
        total++; if (rdy4 !== !m_pend[2]) $display("FAIL bp_ready got %b want %b", rdy4, !m_pend[2]); else pass++;
        n = 0;
        while (m_pend[2] && n < 40) begin
            advance();
            #1;
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL bp_out got %h/%h want %h/%h", clk4, tick4, m_clk, m_tick); else pass++;
            total++; if (rdy4 !== !m_pend[2]) $display("FAIL bp_wait_ready got %b want %b", rdy4, !m_pend[2]); else pass++;
            n++;
        end
        total++; if (n >= 40) $display("FAIL bp_timeout got %0d cycles want <40", n); else pass++;
        advance();
        cfg_valid = 0;
        for (int i = 0; i < 20; i++) begin
            advance();
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL bp_after cyc %0d got %h/%h want %h/%h", i, clk4, tick4, m_clk, m_tick); else pass++;
        end
    endtask

    task automatic test_sync();
        cfg_valid = 1; cfg_ch = 0; cfg_div = 2;
        advance();
        cfg_ch = 1; cfg_div = 5;
        advance();
        cfg_valid = 0;
        for (int i = 0; i < 17; i++) begin
            advance();
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL sync_drift cyc %0d got %h/%h want %h/%h", i, clk4, tick4, m_clk, m_tick); else pass++;
        end
        sync = 1;
        advance();
        sync = 0;
        total++; if (clk4 !== 4'h0 || tick4 !== 4'h0) $display("FAIL sync_clear got %h/%h want 0/0", clk4, tick4); else pass++;
        for (int i = 1; i <= 7; i++) begin
            advance();
            total++; if (clk4[0] !== (i >= 3 && i < 6)) $display("FAIL sync_ch0 +%0d got %b want %b", i, clk4[0], (i >= 3 && i < 6)); else pass++;
            total++; if (clk4[1] !== (i >= 6)) $display("FAIL sync_ch1 +%0d got %b want %b", i, clk4[1], (i >= 6)); else pass++;
            total++; if (tick4[0] !== (i % 3 == 0)) $display("FAIL sync_tick0 +%0d got %b want %b", i, tick4[0], (i % 3 == 0)); else pass++;
        end
    endtask

    task automatic test_enable();
        logic [3:0] hold;
        advance();
        advance();
        hold = m_clk;
        en = 0;
        for (int i = 0; i < 7; i++) begin
            advance();
            total++; if (tick4 !== 4'h0) $display("FAIL en_tick cyc %0d got %h want 0", i, tick4); else pass++;
            total++; if (clk4 !== hold) $display("FAIL en_hold cyc %0d got %h want %h", i, clk4, hold); else pass++;
        end
        en = 1;
        for (int i = 0; i < 20; i++) begin
            advance();
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL en_resume cyc %0d got %h/%h want %h/%h", i, clk4, tick4, m_clk, m_tick); else pass++;
        end
    endtask

    task automatic test_div0();
        logic lastc;
        cfg_valid = 1; cfg_ch = 3; cfg_div = 0;
        advance();
        cfg_valid = 0;
        for (int i = 0; i < 12; i++) begin
            advance();
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL div0_run cyc %0d got %h/%h want %h/%h", i, clk4, tick4, m_clk, m_tick); else pass++;
        end
        lastc = m_clk[3];
        for (int i = 0; i < 8; i++) begin
            advance();
            lastc = ~lastc;
            total++; if (tick4[3] !== 1'b1) $display("FAIL div0_tick cyc %0d got %b want 1", i, tick4[3]); else pass++;
            total++; if (clk4[3] !== lastc) $display("FAIL div0_clk cyc %0d got %b want %b", i, clk4[3], lastc); else pass++;
        end
    endtask

    task automatic test_out_of_range();
        cfg_valid = 1; cfg_ch = 3; cfg_div = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (rdy3 !== 1'b1) $display("FAIL oor_ready cyc %0d got %b want 1", i, rdy3); else pass++;
            advance();
            total++; if (clk3 !== m_clk[2:0] || tick3 !== m_tick[2:0]) $display("FAIL oor_out cyc %0d got %h/%h want %h/%h", i, clk3, tick3, m_clk[2:0], m_tick[2:0]); else pass++;
        end
        cfg_valid = 0;
    endtask

    task automatic test_reset_pending();
        cfg_valid = 1; cfg_ch = 1; cfg_div = 9;
        advance();
        cfg_valid = 0;
        reset = 1;
        advance();
        reset = 0;
        total++; if (clk4 !== 4'h0) $display("FAIL rstp_clk got %h want 0", clk4); else pass++;
        for (int i = 1; i <= 12; i++) begin
            advance();
            total++; if (clk4 !== (((i / 5) % 2) ? 4'hf : 4'h0)) $display("FAIL rstp_clk cyc %0d got %h want %h", i, clk4, ((i / 5) % 2) ? 4'hf : 4'h0); else pass++;
            total++; if (tick4 !== ((i % 5 == 0) ? 4'hf : 4'h0)) $display("FAIL rstp_tick cyc %0d got %h want %h", i, tick4, (i % 5 == 0) ? 4'hf : 4'h0); else pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            en = ($urandom_range(0, 7) != 0);
            sync = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 1) == 1);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = 8'($urandom_range(0, 6));
            #1;
            total++; if (rdy4 !== !m_pend[cfg_ch]) $display("FAIL rnd_ready cyc %0d got %b want %b", i, rdy4, !m_pend[cfg_ch]); else pass++;
            total++; if (rdy3 !== ((cfg_ch == 2'd3) ? 1'b1 : !m_pend[cfg_ch])) $display("FAIL rnd_ready3 cyc %0d got %b", i, rdy3); else pass++;
            advance();
            total++; if (clk4 !== m_clk || tick4 !== m_tick) $display("FAIL rnd_out cyc %0d got %h/%h want %h/%h", i, clk4, tick4, m_clk, m_tick); else pass++;
            total++; if (clk3 !== m_clk[2:0] || tick3 !== m_tick[2:0]) $display("FAIL rnd_out3 cyc %0d got %h/%h want %h/%h", i, clk3, tick3, m_clk[2:0], m_tick[2:0]); else pass++;
`ifdef TICK_CNT_EN
            total++; if (tcnt4[15:0] !== m_rise[0] || tcnt4[63:48] !== m_rise[3]) $display("FAIL rnd_tcnt cyc %0d got %h/%h want %h/%h", i, tcnt4[15:0], tcnt4[63:48], m_rise[0], m_rise[3]); else pass++;
`endif
        end
        reset = 0; en = 1; sync = 0; cfg_valid = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_default();
        test_cfg();
        test_back_to_back();
        test_sync();
        test_enable();
        test_div0();
        test_out_of_range();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
